// File: rtl/sp1_div_pkg.sv
// Shared definitions for the sp1 divider: FSM state encodings and the
// iteration-counter width helper. Used by the sp1_div top.
package sp1_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must hold iteration indices 0..dw-1 with headroom.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/sp1_sub.sv
// Trial subtractor: diff = x - y with a borrow-out flag (borrow=1 when x < y).
module sp1_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // Extend by one bit so the MSB of the wide result is the borrow.
  always_comb begin
    {borrow, diff} = {1'b0, x} - {1'b0, y};
  end

endmodule

// File: rtl/sp1_div.sv
// sp1_div: multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Optional signed mode is compiled in by defining SP1_DIV_SIGNED_EN.
//
// Handshake: rdy is high only in IDLE; a request is accepted on a rising edge
// where req=1 and rdy=1, and a0/a1/sgn are captured on that edge. Requests
// while rdy=0 are dropped. valid pulses for exactly one cycle (DONE) and q/r/dz
// hold their values until the next result is produced.
module sp1_div
  import sp1_div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  output logic          rdy,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic          sgn,
  output logic [DW-1:0] q,
  output logic [DW-1:0] r,
  output logic          valid,
  output logic          dz,
  output logic [1:0]    state_dbg
);

  localparam int CW = cnt_width(DW);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rem;   // partial remainder
  logic [DW-1:0] quo;   // dividend bits shift out the top, quotient bits shift in
  logic [DW-1:0] dvs;   // latched divisor (magnitude)

  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic          borrow;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW-1:0] q_fin;
  logic [DW-1:0] r_fin;
  logic          last;

  assign shifted = {rem, quo[DW-1]};
  assign last    = (cnt == CW'(DW - 1));

  sp1_sub #(.W(DW + 1)) u_sub (
    .x      (shifted),
    .y      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  // One restoring step: keep the difference unless the trial subtraction borrowed.
  always_comb begin
    rem_nxt = borrow ? shifted[DW-1:0] : diff[DW-1:0];
    quo_nxt = {quo[DW-2:0], ~borrow};
  end

`ifdef SP1_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Divide magnitudes; signs are reapplied to the final result.
  always_comb begin
    mag_a = (sgn && a0[DW-1]) ? -a0 : a0;
    mag_b = (sgn && a1[DW-1]) ? -a1 : a1;
    q_fin = neg_q ? -quo_nxt : quo_nxt;
    r_fin = neg_r ? -rem_nxt : rem_nxt;
  end
`else
  logic sgn_unused;
  assign sgn_unused = sgn;

  // Unsigned only: operands and results pass straight through.
  always_comb begin
    mag_a = a0;
    mag_b = a1;
    q_fin = quo_nxt;
    r_fin = rem_nxt;
  end
`endif

  // Control FSM plus datapath registers; results load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
`ifdef SP1_DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (a1 == '0) begin
              q     <= '1;
              r     <= a0;
              dz    <= 1'b1;
              state <= ST_DONE;
            end else begin
              rem   <= '0;
              quo   <= mag_a;
              dvs   <= mag_b;
              cnt   <= '0;
`ifdef SP1_DIV_SIGNED_EN
              neg_q <= sgn && (a0[DW-1] ^ a1[DW-1]);
              neg_r <= sgn && a0[DW-1];
`endif
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            q     <= q_fin;
            r     <= r_fin;
            dz    <= 1'b0;
            cnt   <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdy       = (state == ST_IDLE);
  assign valid     = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_sp1_div.sv
// Self-checking bench for sp1_div (DW=32): directed cases plus a randomized
// run scored against an arithmetic reference model.
module tb_sp1_div;

  localparam int DW = 32;
  localparam int TMO = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req = 1'b0;
  logic          rdy;
  logic [DW-1:0] a0 = '0;
  logic [DW-1:0] a1 = '0;
  logic          sgn = 1'b0;
  logic [DW-1:0] q;
  logic [DW-1:0] r;
  logic          valid;
  logic          dz;
  logic [1:0]    state_dbg;

  sp1_div #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rdy       (rdy),
    .a0        (a0),
    .a1        (a1),
    .sgn       (sgn),
    .q         (q),
    .r         (r),
    .valid     (valid),
    .dz        (dz),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_r[$];
  logic          exp_dz[$];
  int            exp_lat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values.
  task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    longint sa, sb;
    logic [63:0] mq, mr;
    if (b == '0) begin
      exp_q.push_back('1);
      exp_r.push_back(a);
      exp_dz.push_back(1'b1);
      exp_lat.push_back(1);
    end else begin
`ifdef SP1_DIV_SIGNED_EN
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mq = 64'(sa / sb);
        mr = 64'(sa % sb);
      end else begin
        mq = 64'(a) / 64'(b);
        mr = 64'(a) % 64'(b);
      end
`else
      sa = 0;
      sb = longint'(s);
      mq = 64'(a) / 64'(b) + 64'(sa * sb);
      mr = 64'(a) % 64'(b);
`endif
      exp_q.push_back(mq[DW-1:0]);
      exp_r.push_back(mr[DW-1:0]);
      exp_dz.push_back(1'b0);
      exp_lat.push_back(DW + 1);
    end
  endtask

  // ---------------- drivers ----------------
  // Presents a request at a negedge once rdy is seen; returns #1 after the
  // accepting edge with operands scrambled to prove they were captured.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("start_rdy_timeout", 64'(n), 64'(0));
    req = 1'b1; a0 = a; a1 = b; sgn = s;
    model(a, b, s);
    @(posedge clk);
    #1;
    req = 1'b0; a0 = $urandom; a1 = $urandom; sgn = 1'($urandom);
  endtask

  // Waits for valid (bounded), checking latency, busy rdy and the result.
  // poke>0 pulses a spurious request at that sample point.
  task automatic wait_result(input string tag, input int poke);
    int lat;
    logic rdy_seen;
    logic [DW-1:0] eq, er;
    logic ed;
    int el;
    lat = 0;
    rdy_seen = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (poke > 0 && lat == poke) begin
        req = 1'b1; a0 = $urandom; a1 = $urandom;
      end else begin
        req = 1'b0;
      end
      if (valid || lat >= TMO) break;
      if (rdy) rdy_seen = 1'b1;
    end
    req = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_no_expectation"}, 64'(0), 64'(1));
      return;
    end
    eq = exp_q.pop_front(); er = exp_r.pop_front();
    ed = exp_dz.pop_front(); el = exp_lat.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_rdy_busy"}, 64'(rdy_seen), 64'(0));
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
    chk({tag, "_dz"}, 64'(dz), 64'(ed));
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, 64'(valid), 64'(0));
    chk({tag, "_rdy_back"}, 64'(rdy), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    logic [DW-1:0] ra, rb;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(rdy), 64'(1));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_dz", 64'(dz), 64'(0));
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_r", 64'(r), 64'(0));
    rst_n = 1'b1;

    // basic unsigned division
    start_op(32'd100, 32'd7, 1'b0);
    wait_result("div100_7", 0);
    check_idle("div100_7");

    // divide by zero
    start_op(32'h12345678, 32'd0, 1'b0);
    wait_result("divzero", 0);
    check_idle("divzero");

    // max / 1, then req held high through DONE: accepted the cycle after DONE
    start_op(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_result("max_div1", 0);
    req = 1'b1; a0 = 32'd50; a1 = 32'd6; sgn = 1'b0;
    model(32'd50, 32'd6, 1'b0);
    @(negedge clk);
    chk("b2b_idle_rdy", 64'(rdy), 64'(1));
    chk("b2b_valid_low", 64'(valid), 64'(0));
    @(posedge clk);
    #1;
    chk("b2b_accepted", 64'(rdy), 64'(0));
    req = 1'b0;
    wait_result("b2b_50_6", 0);
    check_idle("b2b_50_6");

    // reset during iteration 10
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete(); exp_r.delete(); exp_dz.delete(); exp_lat.delete();
    chk("abort_q", 64'(q), 64'(0));
    chk("abort_r", 64'(r), 64'(0));
    chk("abort_rdy", 64'(rdy), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (DW + 4) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_no_valid", 64'(nv), 64'(0));
    start_op(32'd9, 32'd3, 1'b0);
    wait_result("after_rst_9_3", 0);
    check_idle("after_rst_9_3");

    // spurious request while busy
    start_op(32'hDEADBEEF, 32'h1234, 1'b0);
    wait_result("busy_poke", 6);
    nv = 0;
    repeat (DW + 4) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("busy_poke_extra_valid", 64'(nv), 64'(0));

`ifdef SP1_DIV_SIGNED_EN
    start_op(-32'sd7, 32'd2, 1'b1);
    wait_result("s_m7_2", 0);
    chk("s_m7_2_q_lit", 64'(q), 64'(32'hFFFFFFFD));
    chk("s_m7_2_r_lit", 64'(r), 64'(32'hFFFFFFFF));
    check_idle("s_m7_2");
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_result("s_minneg", 0);
    chk("s_minneg_q_lit", 64'(q), 64'(32'h80000000));
    chk("s_minneg_r_lit", 64'(r), 64'(0));
    check_idle("s_minneg");
`endif

    // randomized operations
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = DW'($urandom_range(1, 15));
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      start_op(ra, rb, 1'($urandom));
      wait_result("rand", 0);
      check_idle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
